// File: rtl/apb_gemm_csr.sv
// APB3/APB4 control/status register block for the GEMM accelerator.
// Optional ACCESS wait states are enabled by defining APB_CSR_WAIT_STATE_EN.
module apb_gemm_csr #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PSTRB_WIDTH = 4,
    parameter int unsigned PPROT_WIDTH = 3,
    parameter int unsigned DIM_WIDTH   = 16,
    parameter logic [31:0] ID_VALUE    = 32'h4745_4D4D,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  s_apb_paddr,
    input  logic                   s_apb_psel,
    input  logic                   s_apb_penable,
    input  logic                   s_apb_pwrite,
    input  logic [DATA_WIDTH-1:0]  s_apb_pwdata,
    input  logic [PSTRB_WIDTH-1:0] s_apb_pstrb,
    input  logic [PPROT_WIDTH-1:0] s_apb_pprot,
    output logic [DATA_WIDTH-1:0]  s_apb_prdata,
    output logic                   s_apb_pready,
    output logic                   s_apb_pslverr,
    output logic                   gemm_start,
    output logic [DIM_WIDTH-1:0]   gemm_m,
    output logic [DIM_WIDTH-1:0]   gemm_n,
    output logic [DIM_WIDTH-1:0]   gemm_k,
    output logic [31:0]            gemm_a_addr,
    output logic [31:0]            gemm_b_addr,
    output logic [31:0]            gemm_c_addr,
    input  logic                   gemm_busy,
    input  logic                   gemm_done,
    output logic                   irq
);

`ifdef APB_CSR_WAIT_STATE_EN
    localparam int unsigned CntW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic unused_ok;
    assign unused_ok = ^{s_apb_pprot, s_apb_paddr[ADDR_WIDTH-1:8]};
`else
    typedef enum logic [0:0] {StIdle, StAccess} state_e;
    logic unused_ok;
    assign unused_ok = ^{s_apb_pprot, s_apb_paddr[ADDR_WIDTH-1:8], (WAIT_STATES == 0)};
`endif

    state_e                 state_q, state_d;
    logic [7:0]             off_q, off_d;
    logic                   write_q, write_d, err_q, err_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, prdata_q, prdata_d;
    logic [PSTRB_WIDTH-1:0] strb_q, strb_d;
    logic                   pready_q, pready_d, pslverr_q, pslverr_d;
    logic                   gemm_start_q, gemm_start_d, irq_q, irq_d;
    logic                   irq_en_q, irq_en_d, done_q, done_d;
    logic [DIM_WIDTH-1:0]   m_q, m_d, n_q, n_d, k_q, k_d;
    logic [31:0]            a_q, a_d, b_q, b_d, c_q, c_d;

    logic [7:0]            off;
    logic                  setup_err, is_cfg, commit, clr_done;
    logic [DATA_WIDTH-1:0] rdata;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0]  old_val,
        input logic [DATA_WIDTH-1:0]  new_val,
        input logic [PSTRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < PSTRB_WIDTH; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign off = s_apb_paddr[7:0];

    // Error check and read mux evaluated on the live SETUP-cycle inputs.
    always_comb begin
        setup_err = 1'b0;
        rdata     = '0;
        is_cfg    = (off >= 8'h08) && (off <= 8'h1C);
        if (off[1:0] != 2'b00 || off > 8'h20) begin
            setup_err = 1'b1;
        end else if (s_apb_pwrite) begin
            if (off == 8'h20) setup_err = 1'b1;
            if (is_cfg && gemm_busy) setup_err = 1'b1;
            if (off == 8'h00 && s_apb_pstrb[0] && s_apb_pwdata[0] && gemm_busy) setup_err = 1'b1;
        end
        case (off)
            8'h00:   rdata = DATA_WIDTH'({irq_en_q, 1'b0});
            8'h04:   rdata = DATA_WIDTH'({done_q, gemm_busy});
            8'h08:   rdata = DATA_WIDTH'(m_q);
            8'h0C:   rdata = DATA_WIDTH'(n_q);
            8'h10:   rdata = DATA_WIDTH'(k_q);
            8'h14:   rdata = a_q;
            8'h18:   rdata = b_q;
            8'h1C:   rdata = c_q;
            8'h20:   rdata = ID_VALUE;
            default: rdata = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        err_d     = err_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        commit    = 1'b0;
`ifdef APB_CSR_WAIT_STATE_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (s_apb_psel && !s_apb_penable) begin
                    off_d    = off;
                    write_d  = s_apb_pwrite;
                    wdata_d  = s_apb_pwdata;
                    strb_d   = s_apb_pstrb;
                    err_d    = setup_err;
                    prdata_d = (!s_apb_pwrite && !setup_err) ? rdata : '0;
`ifdef APB_CSR_WAIT_STATE_EN
                    if (WAIT_STATES == 0) begin
                        state_d   = StAccess;
                        pready_d  = 1'b1;
                        pslverr_d = setup_err;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntW'(WAIT_STATES - 1);
                    end
`else
                    state_d   = StAccess;
                    pready_d  = 1'b1;
                    pslverr_d = setup_err;
`endif
                end
            end
`ifdef APB_CSR_WAIT_STATE_EN
            StWait: begin
                if (cnt_q == '0) begin
                    state_d   = StAccess;
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            StAccess: begin
                commit    = s_apb_psel && s_apb_penable && write_q && !err_q;
                state_d   = StIdle;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        irq_en_d     = irq_en_q;
        m_d          = m_q;
        n_d          = n_q;
        k_d          = k_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        gemm_start_d = 1'b0;
        clr_done     = 1'b0;
        if (commit) begin
            case (off_q)
                8'h00: if (strb_q[0]) begin
                    irq_en_d     = wdata_q[1];
                    gemm_start_d = wdata_q[0];
                    clr_done     = wdata_q[0] | wdata_q[2];
                end
                8'h04: if (strb_q[0]) clr_done = wdata_q[1];
                8'h08: m_d = DIM_WIDTH'(merge_bytes(DATA_WIDTH'(m_q), wdata_q, strb_q));
                8'h0C: n_d = DIM_WIDTH'(merge_bytes(DATA_WIDTH'(n_q), wdata_q, strb_q));
                8'h10: k_d = DIM_WIDTH'(merge_bytes(DATA_WIDTH'(k_q), wdata_q, strb_q));
                8'h14: a_d = merge_bytes(a_q, wdata_q, strb_q);
                8'h18: b_d = merge_bytes(b_q, wdata_q, strb_q);
                8'h1C: c_d = merge_bytes(c_q, wdata_q, strb_q);
                default: ;
            endcase
        end
        // A completion arriving on the clearing edge must not be lost.
        done_d = (done_q & ~clr_done) | gemm_done;
        irq_d  = done_q & irq_en_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            off_q        <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            strb_q       <= '0;
            err_q        <= 1'b0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            prdata_q     <= '0;
            gemm_start_q <= 1'b0;
            irq_q        <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            m_q          <= '0;
            n_q          <= '0;
            k_q          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
`ifdef APB_CSR_WAIT_STATE_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            strb_q       <= strb_d;
            err_q        <= err_d;
            pready_q     <= pready_d;
            pslverr_q    <= pslverr_d;
            prdata_q     <= prdata_d;
            gemm_start_q <= gemm_start_d;
            irq_q        <= irq_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            m_q          <= m_d;
            n_q          <= n_d;
            k_q          <= k_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
`ifdef APB_CSR_WAIT_STATE_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign s_apb_prdata  = prdata_q;
    assign s_apb_pready  = pready_q;
    assign s_apb_pslverr = pslverr_q;
    assign gemm_start    = gemm_start_q;
    assign gemm_m        = m_q;
    assign gemm_n        = n_q;
    assign gemm_k        = k_q;
    assign gemm_a_addr   = a_q;
    assign gemm_b_addr   = b_q;
    assign gemm_c_addr   = c_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_apb_gemm_csr.sv
// Self-checking bench for apb_gemm_csr: directed vector table, corner sequences,
// then random APB traffic scored against a register-map model.
module tb_apb_gemm_csr;
    localparam int WS = 2;
`ifdef APB_CSR_WAIT_STATE_EN
    localparam int ExpCyc = (WS == 0) ? 1 : WS + 1;
`else
    localparam int ExpCyc = 1;
`endif
    localparam logic [31:0] IdVal = 32'h4745_4D4D;

    logic        clk = 1'b0, reset = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0, prdata;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic        pready, pslverr, gemm_start, irq;
    logic [15:0] gemm_m, gemm_n, gemm_k;
    logic [31:0] gemm_a, gemm_b, gemm_c;
    logic        gemm_busy = 1'b0, gemm_done = 1'b0;

    int n_checks = 0, n_errs = 0;

    // Reference model state
    logic        irq_en_m, done_m;
    logic [31:0] cfg_m [6];

    apb_gemm_csr #(.WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .s_apb_paddr(paddr), .s_apb_psel(psel), .s_apb_penable(penable),
        .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb),
        .s_apb_pprot(pprot), .s_apb_prdata(prdata), .s_apb_pready(pready),
        .s_apb_pslverr(pslverr), .gemm_start(gemm_start),
        .gemm_m(gemm_m), .gemm_n(gemm_n), .gemm_k(gemm_k),
        .gemm_a_addr(gemm_a), .gemm_b_addr(gemm_b), .gemm_c_addr(gemm_c),
        .gemm_busy(gemm_busy), .gemm_done(gemm_done), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        irq_en_m = 1'b0;
        done_m   = 1'b0;
        for (int i = 0; i < 6; i++) cfg_m[i] = '0;
    endtask

    task automatic model_apply(input logic wr, input logic [7:0] off, input logic [31:0] wd,
                               input logic [3:0] st, input logic busy,
                               output logic e, output logic [31:0] rd, output logic s);
        int idx;
        e = 1'b0; rd = '0; s = 1'b0;
        idx = (int'(off) - 8) / 4;
        if (off[1:0] != 2'b00 || off > 8'h20) e = 1'b1;
        else if (wr && off == 8'h20) e = 1'b1;
        else if (wr && off >= 8'h08 && off <= 8'h1C && busy) e = 1'b1;
        else if (wr && off == 8'h00 && st[0] && wd[0] && busy) e = 1'b1;
        if (!e && !wr) begin
            if (off == 8'h00) rd = {30'd0, irq_en_m, 1'b0};
            else if (off == 8'h04) rd = {30'd0, done_m, busy};
            else if (off == 8'h20) rd = IdVal;
            else rd = cfg_m[idx];
        end else if (!e) begin
            if (off >= 8'h08 && off <= 8'h1C) begin
                for (int b = 0; b < 4; b++) if (st[b]) cfg_m[idx][8*b +: 8] = wd[8*b +: 8];
                if (idx < 3) cfg_m[idx][31:16] = '0;
            end else if (off == 8'h00 && st[0]) begin
                irq_en_m = wd[1];
                if (wd[0]) begin s = 1'b1; done_m = 1'b0; end
                if (wd[2]) done_m = 1'b0;
            end else if (off == 8'h04 && st[0] && wd[1]) begin
                done_m = 1'b0;
            end
        end
    endtask

    // One full APB transfer; compares against the model and returns what the DUT showed.
    task automatic do_xfer(input logic wr, input logic [7:0] off, input logic [31:0] wd,
                           input logic [3:0] st, input logic done_at_commit,
                           output logic err, output logic [31:0] rd, output logic spulse,
                           output int cyc);
        logic [31:0] hi;
        logic        e_m, s_m;
        logic [31:0] rd_m;
        hi = $urandom;
        @(negedge clk);
        paddr = {hi[31:8], off}; psel = 1'b1; penable = 1'b0; pwrite = wr;
        pwdata = wd; pstrb = st; pprot = 3'($urandom);
        @(negedge clk);
        penable = 1'b1;
        cyc = 1;
        while (!pready && cyc < 32) begin
            @(negedge clk);
            cyc++;
        end
        if (!pready) chk("pready_timeout", 192'(pready), 192'(1));
        rd = prdata; err = pslverr;
        gemm_done = done_at_commit;
        model_apply(wr, off, wd, st, gemm_busy, e_m, rd_m, s_m);
        if (done_at_commit) done_m = 1'b1;
        @(negedge clk);
        spulse = gemm_start;
        psel = 1'b0; penable = 1'b0; gemm_done = 1'b0;
        chk("model_pslverr", 192'(err), 192'(e_m));
        chk("model_prdata", 192'(rd), 192'(rd_m));
        chk("model_start", 192'(spulse), 192'(s_m));
        chk("idle_pready_prdata", {pready, prdata}, 192'(0));
        @(negedge clk);
        chk("start_one_cycle", 192'(gemm_start), 192'(0));
        chk("model_irq", 192'(irq), 192'(done_m & irq_en_m));
        chk("model_cfg", {gemm_m, gemm_n, gemm_k, gemm_a, gemm_b, gemm_c},
            {cfg_m[0][15:0], cfg_m[1][15:0], cfg_m[2][15:0], cfg_m[3], cfg_m[4], cfg_m[5]});
    endtask

    task automatic pulse_done();
        @(negedge clk); gemm_done = 1'b1;
        @(negedge clk); gemm_done = 1'b0;
        done_m = 1'b1;
        @(negedge clk);
        chk("model_irq_after_done", 192'(irq), 192'(done_m & irq_en_m));
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  off;
        logic [31:0] wd;
        logic [3:0]  st;
        logic        busy;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    initial begin
        vec_t        vt [19];
        logic        err, sp;
        logic [31:0] rd;
        int          cyc;

        vt[0]  = '{1'b1, 8'h08, 32'h0000_0040, 4'hF, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 8'h08, 32'h0,         4'hF, 1'b0, 1'b0, 32'h0000_0040};
        vt[2]  = '{1'b1, 8'h1C, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 8'h1C, 32'h0,         4'hF, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vt[4]  = '{1'b1, 8'h14, 32'hAAAA_AAAA, 4'hF, 1'b0, 1'b0, 32'h0};
        vt[5]  = '{1'b1, 8'h14, 32'h1122_3344, 4'h5, 1'b0, 1'b0, 32'h0};
        vt[6]  = '{1'b0, 8'h14, 32'h0,         4'hF, 1'b0, 1'b0, 32'hAA22_AA44};
        vt[7]  = '{1'b0, 8'h20, 32'h0,         4'hF, 1'b0, 1'b0, IdVal};
        vt[8]  = '{1'b1, 8'h20, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 32'h0};
        vt[9]  = '{1'b0, 8'h24, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0};
        vt[10] = '{1'b0, 8'h02, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0};
        vt[11] = '{1'b1, 8'h0C, 32'h0000_0005, 4'hF, 1'b0, 1'b0, 32'h0};
        vt[12] = '{1'b1, 8'h0C, 32'h0000_0009, 4'hF, 1'b1, 1'b1, 32'h0};
        vt[13] = '{1'b0, 8'h0C, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0000_0005};
        vt[14] = '{1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 32'h0};
        vt[15] = '{1'b0, 8'h10, 32'h0,         4'hF, 1'b0, 1'b0, 32'h0000_FFFF};
        vt[16] = '{1'b0, 8'h04, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0000_0001};
        vt[17] = '{1'b1, 8'h00, 32'h0000_0001, 4'hF, 1'b1, 1'b1, 32'h0};
        vt[18] = '{1'b0, 8'h00, 32'h0,         4'hF, 1'b0, 1'b0, 32'h0};

        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {prdata, pready, pslverr, gemm_start, irq, gemm_m, gemm_n, gemm_k,
                              gemm_a, gemm_b, gemm_c}, 192'(0));
        reset = 1'b1;

        foreach (vt[i]) begin
            gemm_busy = vt[i].busy;
            do_xfer(vt[i].wr, vt[i].off, vt[i].wd, vt[i].st, 1'b0, err, rd, sp, cyc);
            chk($sformatf("vec%0d_pslverr", i), 192'(err), 192'(vt[i].exp_err));
            chk($sformatf("vec%0d_prdata", i), 192'(rd), 192'(vt[i].exp_rd));
        end

        // Start pulse, access-phase length
        gemm_busy = 1'b0;
        do_xfer(1'b1, 8'h00, 32'h3, 4'hF, 1'b0, err, rd, sp, cyc);
        chk("start_pulse", 192'(sp), 192'(1));
        chk("access_cycles", 192'(cyc), 192'(ExpCyc));

        // Config write blocked while busy
        gemm_busy = 1'b1;
        do_xfer(1'b1, 8'h0C, 32'hBEEF, 4'hF, 1'b0, err, rd, sp, cyc);
        chk("busy_wr_err", 192'(err), 192'(1));
        do_xfer(1'b0, 8'h0C, 32'h0, 4'hF, 1'b0, err, rd, sp, cyc);
        chk("busy_wr_unchanged", 192'(rd), 192'(5));

        // Done -> STATUS and irq; W1C clears
        gemm_busy = 1'b0;
        pulse_done();
        chk("irq_set", 192'(irq), 192'(1));
        do_xfer(1'b0, 8'h04, 32'h0, 4'hF, 1'b0, err, rd, sp, cyc);
        chk("status_done", 192'(rd), 192'(2));
        do_xfer(1'b1, 8'h04, 32'h2, 4'hF, 1'b0, err, rd, sp, cyc);
        chk("irq_cleared", 192'(irq), 192'(0));

        // Done pulse coincident with W1C commit: set wins
        pulse_done();
        do_xfer(1'b1, 8'h04, 32'h2, 4'hF, 1'b1, err, rd, sp, cyc);
        do_xfer(1'b0, 8'h04, 32'h0, 4'hF, 1'b0, err, rd, sp, cyc);
        chk("done_set_wins", 192'(rd), 192'(2));

        // Reset asserted during ACCESS of a write
        @(negedge clk);
        paddr = 32'h08; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        pwdata = 32'h77; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1; reset = 1'b0;
        @(negedge clk);
        chk("reset_mid_access", {prdata, pready, pslverr, gemm_start, irq, gemm_m, gemm_n, gemm_k,
                                 gemm_a, gemm_b, gemm_c}, 192'(0));
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        do_xfer(1'b0, 8'h08, 32'h0, 4'hF, 1'b0, err, rd, sp, cyc);
        chk("reset_no_commit", 192'(rd), 192'(0));

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [7:0] off;
            if ($urandom_range(0, 7) == 0) off = 8'($urandom_range(0, 255));
            else off = 8'($urandom_range(0, 9) * 4);
            gemm_busy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) pulse_done();
            do_xfer(1'($urandom_range(0, 1)), off, $urandom, 4'($urandom),
                    ($urandom_range(0, 7) == 0), err, rd, sp, cyc);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
